// File: rtl/bch31_enc_framer.sv
// Serial BCH(31,21) systematic encoder framer: collects 21 data bits, appends the
// 10 parity bits and emits the 31-bit codeword MSB first on a valid/ready stream.
`timescale 1ns/1ps

module bch31_parity_gen #(
    parameter int P_D_WIDTH = 21,
    parameter int P_P_WIDTH = 10
) (
    input  logic [P_D_WIDTH-1:0] data,
    output logic [P_P_WIDTH-1:0] parity
);

    // Low-order taps of g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1; the x^10 term is the feedback.
    localparam logic [P_P_WIDTH-1:0] G_TAPS = P_P_WIDTH'(10'h369);

    logic [P_P_WIDTH-1:0] rem;
    logic                 fb;

    // Unrolled division LFSR: remainder of d(x)*x^10 by g(x), MSB of data first.
    always_comb begin
        rem = '0;
        fb  = 1'b0;
        for (int i = P_D_WIDTH - 1; i >= 0; i--) begin
            fb  = data[i] ^ rem[P_P_WIDTH-1];
            rem = {rem[P_P_WIDTH-2:0], 1'b0} ^ (fb ? G_TAPS : '0);
        end
        parity = rem;
    end

endmodule

module bch31_enc_framer #(
    parameter int P_D_WIDTH   = 21,
    parameter int P_P_WIDTH   = 10,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    input  logic                   s_data_i,
    output logic                   s_ready_o,
    output logic                   m_valid_o,
    output logic                   m_data_o,
    input  logic                   m_ready_i,
    output logic                   m_sof_o,
    output logic                   m_eof_o,
    output logic [P_CNT_WIDTH-1:0] cw_cnt_o
);

    localparam int CW_WIDTH = P_D_WIDTH + P_P_WIDTH;
    localparam logic [4:0] IN_LAST  = 5'(P_D_WIDTH - 1);
    localparam logic [4:0] OUT_LAST = 5'(CW_WIDTH - 1);

    if (P_D_WIDTH != 21) begin : g_bad_d_width
        $error("bch31_enc_framer: P_D_WIDTH must be 21");
    end
    if (P_P_WIDTH != 10) begin : g_bad_p_width
        $error("bch31_enc_framer: P_P_WIDTH must be 10");
    end

    logic [P_D_WIDTH-1:0]   hold_sr;
    logic [4:0]             in_cnt;
    logic                   word_full;
    logic [CW_WIDTH-1:0]    out_sr;
    logic [4:0]             out_cnt;
    logic                   out_valid;
    logic [P_CNT_WIDTH-1:0] cw_cnt;
    logic [P_P_WIDTH-1:0]   parity;

    logic accept_in;
    logic beat;
    logic last_beat;
    logic out_free;
    logic transfer;

    bch31_parity_gen #(
        .P_D_WIDTH (P_D_WIDTH),
        .P_P_WIDTH (P_P_WIDTH)
    ) u_parity (
        .data   (hold_sr),
        .parity (parity)
    );

    // The output side is free when idle or finishing its last beat this edge,
    // which lets a held word follow an eof beat with no bubble.
    assign accept_in = s_valid_i && !word_full;
    assign beat      = out_valid && m_ready_i;
    assign last_beat = beat && (out_cnt == OUT_LAST);
    assign out_free  = !out_valid || last_beat;
    assign transfer  = word_full && out_free;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_sr   <= '0;
            in_cnt    <= '0;
            word_full <= 1'b0;
        end else begin
            if (accept_in) begin
                hold_sr <= {hold_sr[P_D_WIDTH-2:0], s_data_i};
                if (in_cnt == IN_LAST) begin
                    in_cnt    <= '0;
                    word_full <= 1'b1;
                end else begin
                    in_cnt <= in_cnt + 5'd1;
                end
            end else if (transfer) begin
                word_full <= 1'b0;
            end
        end
    end

    // A transfer always wins over the shift; out_cnt parks at the last index when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_sr    <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            cw_cnt    <= '0;
        end else begin
            if (transfer) begin
                out_sr    <= {hold_sr, parity};
                out_cnt   <= '0;
                out_valid <= 1'b1;
            end else if (beat) begin
                out_sr <= {out_sr[CW_WIDTH-2:0], 1'b0};
                if (last_beat) begin
                    out_valid <= 1'b0;
                end else begin
                    out_cnt <= out_cnt + 5'd1;
                end
            end
            if (last_beat) begin
                cw_cnt <= cw_cnt + P_CNT_WIDTH'(1);
            end
        end
    end

    assign s_ready_o = !word_full;
    assign m_valid_o = out_valid;
    assign m_data_o  = out_sr[CW_WIDTH-1];
    assign m_sof_o   = out_valid && (out_cnt == 5'd0);
    assign m_eof_o   = out_valid && (out_cnt == OUT_LAST);
    assign cw_cnt_o  = cw_cnt;

endmodule

// File: tb/tb_bch31_enc_framer.sv
// Self-checking bench for bch31_enc_framer: directed words with hand-computed
// codewords, random words checked against a linear parity model, framing and backpressure.
`timescale 1ns/1ps

module tb_bch31_enc_framer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_valid_i;
    logic        s_data_i;
    logic        s_ready_o;
    logic        m_valid_o;
    logic        m_data_o;
    logic        m_ready_i = 1'b1;
    logic        m_sof_o;
    logic        m_eof_o;
    logic [15:0] cw_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc         = 0;
    int accept_cyc  = 0;
    int sof_cyc     = 0;
    int words_done  = 0;
    int words_sent  = 0;
    int gap_cnt     = 0;
    int gap_target  = 0;
    int ready_mode  = 0;
    logic gap_watch   = 1'b0;
    logic gap_started = 1'b0;

    logic [30:0] exp_q[$];
    logic [9:0]  basis[21];

    int          bitpos     = 0;
    int          flag_err   = 0;
    logic [30:0] cw_acc     = '0;
    logic        prev_stall = 1'b0;
    logic        prev_data  = 1'b0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    bch31_enc_framer #(
        .P_D_WIDTH   (21),
        .P_P_WIDTH   (10),
        .P_CNT_WIDTH (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .m_sof_o   (m_sof_o),
        .m_eof_o   (m_eof_o),
        .cw_cnt_o  (cw_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Parity is linear in d, so it is the XOR of x^(10+i) mod g over the set bits.
    function automatic logic [30:0] encode(input logic [20:0] d);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 21; i++) begin
            if (d[i]) p = p ^ basis[i];
        end
        return {d, p};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = ($urandom_range(3) != 0);
            default: m_ready_i = 1'b0;
        endcase
    end

    // Output monitor: rebuilds codewords, checks framing flags and hold-under-stall.
    always @(negedge clk) begin
        if (rst_i) begin
            bitpos     = 0;
            flag_err   = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid_held", {63'd0, m_valid_o}, 64'd1);
                checkOutput("stall_data_held", {63'd0, m_data_o}, {63'd0, prev_data});
            end
            if (m_valid_o && !prev_valid) sof_cyc = cyc;
            if (gap_watch && gap_started && words_done < gap_target && !m_valid_o) gap_cnt++;
            if (gap_watch && m_valid_o) gap_started = 1'b1;
            if (m_valid_o && m_ready_i) begin
                if (m_sof_o !== (bitpos == 0) || m_eof_o !== (bitpos == 30)) flag_err++;
                cw_acc = {cw_acc[29:0], m_data_o};
                if (bitpos == 30) begin
                    checkOutput("cw_expected_pending", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0) checkOutput("codeword", {33'd0, cw_acc}, {33'd0, exp_q.pop_front()});
                    checkOutput("sof_eof_framing", 64'(flag_err), 64'd0);
                    flag_err = 0;
                    bitpos   = 0;
                    words_done++;
                end else begin
                    bitpos++;
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_valid = m_valid_o;
        end
    end

    task automatic applyStimulus(input logic [20:0] d, input int nbits, input int gap_pct,
                                 input logic [30:0] exp_cw);
        int guard;
        if (nbits == 21) begin
            exp_q.push_back(exp_cw);
            words_sent++;
        end
        for (int i = 20; i > 20 - nbits; i--) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            s_valid_i = 1'b1;
            s_data_i  = d[i];
            guard     = 0;
            forever begin
                @(negedge clk);
                if (s_ready_o) begin
                    accept_cyc = cyc;
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                guard++;
                if (guard > 500) begin
                    checkOutput("input_ready_timeout", {63'd0, s_ready_o}, 64'd1);
                    break;
                end
            end
        end
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid_o) break;
            guard++;
            if (guard > 5000) begin
                checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        s_valid_i = 1'b0;
        rst_i     = 1'b1;
        exp_q.delete();
        words_sent = 0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_s_ready"}, {63'd0, s_ready_o}, 64'd1);
        checkOutput({tag, "_m_valid"}, {63'd0, m_valid_o}, 64'd0);
        checkOutput({tag, "_m_data"},  {63'd0, m_data_o},  64'd0);
        checkOutput({tag, "_m_sof"},   {63'd0, m_sof_o},   64'd0);
        checkOutput({tag, "_m_eof"},   {63'd0, m_eof_o},   64'd0);
        checkOutput({tag, "_cw_cnt"},  {48'd0, cw_cnt_o},  64'd0);
    endtask

    initial begin
        logic [9:0]  m;
        logic [20:0] wa;
        logic [20:0] wb;
        logic [30:0] cwa;
        int          guard;

        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = 1'b0;
        m = 10'h369;
        for (int i = 0; i < 21; i++) begin
            basis[i] = m;
            m = {m[8:0], 1'b0} ^ (m[9] ? 10'h369 : 10'h000);
        end
        repeat (2) @(posedge clk);
        #1;
        doReset();
        checkReset("reset");

        // All-zero word, then the single-bit words with hand-derived parity.
        applyStimulus(21'h000000, 21, 0, 31'h00000000);
        s_valid_i = 1'b0;
        waitDrain();
        checkOutput("cw_cnt_after_zero", {48'd0, cw_cnt_o}, 64'd1);

        applyStimulus(21'h000001, 21, 0, 31'h00000769);
        s_valid_i = 1'b0;
        waitDrain();
        checkOutput("first_valid_latency", 64'(sof_cyc - accept_cyc), 64'd2);
        checkOutput("cw_cnt_after_one", {48'd0, cw_cnt_o}, 64'd2);

        applyStimulus(21'h000002, 21, 0, 31'h000009BB);
        s_valid_i = 1'b0;
        waitDrain();

        // Random words with input gaps and random downstream backpressure.
        ready_mode = 1;
        for (int n = 0; n < 20; n++) begin
            wa = 21'($urandom);
            applyStimulus(wa, 21, 30, encode(wa));
        end
        s_valid_i  = 1'b0;
        ready_mode = 0;
        waitDrain();
        checkOutput("cw_cnt_after_random", {48'd0, cw_cnt_o}, 64'(words_sent));

        // Continuous input and output: no gaps between codewords.
        gap_cnt     = 0;
        gap_started = 1'b0;
        gap_target  = words_done + 10;
        gap_watch   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            wa = 21'($urandom);
            applyStimulus(wa, 21, 0, encode(wa));
        end
        s_valid_i = 1'b0;
        waitDrain();
        gap_watch = 1'b0;
        checkOutput("back_to_back_gaps", 64'(gap_cnt), 64'd0);
        checkOutput("cw_cnt_after_b2b", {48'd0, cw_cnt_o}, 64'(words_sent));

        // Long stall with one codeword in flight and a second word held.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        wa  = 21'h1A5C3E;
        wb  = 21'h0F0F0F;
        cwa = encode(wa);
        applyStimulus(wa, 21, 0, cwa);
        applyStimulus(wb, 21, 0, encode(wb));
        s_valid_i = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("stall_s_ready_low", {63'd0, s_ready_o}, 64'd0);
        checkOutput("stall_m_valid_high", {63'd0, m_valid_o}, 64'd1);
        checkOutput("stall_m_data_first_bit", {63'd0, m_data_o}, {63'd0, cwa[30]});
        checkOutput("stall_m_sof_high", {63'd0, m_sof_o}, 64'd1);
        ready_mode = 0;
        waitDrain();
        checkOutput("cw_cnt_after_stall", {48'd0, cw_cnt_o}, 64'(words_sent));

        // Reset after 10 input bits; the next word must start cleanly.
        applyStimulus(21'h155555, 10, 0, 31'h0);
        doReset();
        checkReset("reset_mid_collect");
        applyStimulus(21'h000002, 21, 0, 31'h000009BB);
        s_valid_i = 1'b0;
        waitDrain();
        checkOutput("cw_cnt_after_collect_reset", {48'd0, cw_cnt_o}, 64'd1);

        // Reset while bit 15 of a codeword is on the output.
        wa = 21'h0ABCDE;
        applyStimulus(wa, 21, 0, encode(wa));
        s_valid_i = 1'b0;
        guard = 0;
        while (bitpos != 15 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_bit15", 64'(bitpos), 64'd15);
        @(posedge clk); #1;
        doReset();
        checkReset("reset_mid_emit");
        applyStimulus(21'h000001, 21, 0, 31'h00000769);
        s_valid_i = 1'b0;
        waitDrain();
        checkOutput("cw_cnt_after_emit_reset", {48'd0, cw_cnt_o}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bch31_enc_framer.md
# bch31_enc_framer

Serial-in/serial-out systematic encoder framer for the DEC BCH(31,21) code. It collects 21 data bits from a valid/ready bit stream and computes the 10 parity bits through one instance of the team's combinational BCH(31,21) parity generator, configured as parity generator rather than syndrome generator. It then emits the 31-bit codeword serially on a second valid/ready stream. It sits directly upstream of the channel/modulator and feeds the parity generator its data words.

## Interface
- P_D_WIDTH, 21, data bits per codeword; fixed, elaboration error if not 21.
- P_P_WIDTH, 10, parity bits per codeword; fixed, elaboration error if not 10.
- P_CNT_WIDTH, 16, width of codeword counter.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- s_valid_i  in  1  input bit valid.
- s_data_i  in  1  input data bit, word MSB first (d[20] first).
- s_ready_o  out  1  framer can accept an input bit.
- m_valid_o  out  1  output codeword bit valid.
- m_data_o  out  1  output codeword bit.
- m_ready_i  in  1  downstream accepts output bit.
- m_sof_o  out  1  current output bit is codeword bit 0 (c[30]).
- m_eof_o  out  1  current output bit is codeword bit 30 (c[0]).
- cw_cnt_o  out  P_CNT_WIDTH  count of fully emitted codewords.

## Operation
- Code: generator g(x)=x^10+x^9+x^8+x^6+x^5+x^3+1. Codeword c={d[20:0],p[9:0]}, with p = d(x)·x^10 mod g(x).
- Emission order: c[30] (=d[20]) first, c[0] (=p[0]) last.
- Input side:
  - 21-bit shift register plus in_cnt (0..20).
  - A bit is accepted when s_valid_i && s_ready_o; the register shifts left, inserting s_data_i.
  - When the bit accepted has in_cnt==20: set word_full, reset in_cnt to 0.
  - s_ready_o = !word_full.
- Transfer happens on the edge where word_full==1 and the output side is free:
  - Free means !m_valid_o, or (m_valid_o && m_ready_i && out_cnt==30).
  - On transfer: load the 31-bit output shift register with {hold, parity(hold)}, set out_cnt=0, m_valid_o=1, clear word_full.
  - Parity is combinational from the hold register, so there is no extra cycle.
- Output side:
  - m_data_o = out_sr[30].
  - On each accepted beat (m_valid_o && m_ready_i), shift left and increment out_cnt.
  - On the beat with out_cnt==30: increment cw_cnt_o (wraps modulo 2^P_CNT_WIDTH), and drop m_valid_o unless a transfer occurs on the same edge.
- m_sof_o = m_valid_o && out_cnt==0. m_eof_o = m_valid_o && out_cnt==30.
- AXI-style rules:
  - m_valid_o and m_data_o are held stable while m_valid_o && !m_ready_i.
  - m_valid_o never depends combinationally on m_ready_i.
- Input collection of the next word proceeds while the current codeword is being emitted (single-word overlap).
- Implicit states: EMPTY (!word_full, !m_valid), COLLECT, HOLD (word_full waiting for the output side), EMIT. Transitions follow the rules above.

## Timing
- Reset values: s_ready_o=1 (first cycle after reset), m_valid_o=0, m_data_o=0, m_sof_o=0, m_eof_o=0, cw_cnt_o=0. in_cnt, out_cnt, word_full and the shift registers are all cleared.
- Reset mid-operation discards any partial input word, held word and in-flight codeword. No partial codeword is emitted after reset.
- Latency: with the output side idle, if the 21st bit is accepted at edge T, then word_full=1 after T, transfer occurs at T+1, and m_valid_o/m_sof_o are high in the cycle after T+1.
- Back-to-back: with s_valid_i and m_ready_i held at 1, the output stream is continuous, with no gap between c[0] of word n and c[30] of word n+1. The input is throttled to 21 bits per 31 cycles.
- Simultaneous events:
  - 21st input bit accepted on the same edge as an eof beat: word_full sets, and the transfer occurs on the next edge. A one-cycle output bubble is allowed only in this case.
  - Transfer and eof beat on the same edge: the new codeword loads and m_valid_o stays 1.
- in_cnt wraps 20→0. out_cnt wraps 30→0 only via transfer.

## Test plan
- Reset then d=21'h000000, m_ready_i=1 -> 31 zero bits; m_sof_o on the first bit, m_eof_o on the 31st; cw_cnt_o=1.
- d=21'h000001 -> codeword 31'h00000769 (p=10'h369) MSB first; first m_valid_o two cycles after the 21st input beat.
- 100 random words, s_valid_i and m_ready_i randomly toggled -> every codeword equals {d, d·x^10 mod g}; data held stable under backpressure; cw_cnt_o=100.
- s_valid_i=1, m_ready_i=1 continuous for 10 words -> no output gaps after the first codeword; s_ready_o low while a word is held.
- m_ready_i=0 for 50 cycles with a full word held -> s_ready_o=0, m_valid_o=1 and m_data_o constant; on release, the stream resumes bit-exact.
- Assert rst_i for 1 cycle mid-collection (10 bits in) and mid-emission (bit 15 out) -> outputs at reset values next cycle; the next 21 bits form a clean new word.
